// File: rtl/shift_seq_pkg.sv
// Shared opcodes, control-bit layout and FSM encoding for the shifter sequencer.
package shift_seq_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_LOAD_DBL = 2'b10;
  localparam logic [1:0] OP_INC      = 2'b11;

  // Bit positions inside the shifter control word
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DBL = 1;
  localparam int CTRL_OP  = 2;

  // Complete pulse encodings driven toward the shifter
  localparam logic [2:0] CTRL_IDLE     = 3'b000;
  localparam logic [2:0] CTRL_LOAD     = 3'b001;
  localparam logic [2:0] CTRL_LOAD_DBL = 3'b011;
  localparam logic [2:0] CTRL_INC      = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/shift_ref_model.sv
// Shadow copy of the shifter's data register and operation counter.
// Applies each issued pulse on the same edge the shifter samples it.
module shift_ref_model
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] exp_data_o,
  output logic [CNT_W-1:0]  exp_counter_o
);

  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: operation bit wins, then double, otherwise plain load
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (ctrl_i[CTRL_EN]) begin
      if (ctrl_i[CTRL_OP]) begin
        data_d = data_q + DATA_ONE;
        cnt_d  = cnt_q + CNT_ONE;
      end else if (ctrl_i[CTRL_DBL]) begin
        data_d = {data_i[DATA_W-2:0], 1'b0};
      end else begin
        data_d = data_i;
      end
    end
  end

  // Model registers, cleared asynchronously with the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign exp_data_o    = data_q;
  assign exp_counter_o = cnt_q;

endmodule

// File: rtl/shift_op_sequencer.sv
// Command-driven pulse generator for the 4-bit shifter/counter datapath.
// Expands LOAD / LOAD_DBL / INC commands into registered control pulses and
// compares the shifter's outputs against a shadow model one cycle after each pulse.
module shift_op_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [2:0]        ctrl,
  output logic [DATA_W-1:0] dut_data,
  input  logic [DATA_W-1:0] dut_data_out,
  input  logic [CNT_W-1:0]  dut_counter,
  output logic              busy,
  output logic [DATA_W-1:0] exp_data,
  output logic [CNT_W-1:0]  exp_counter,
  output logic              mismatch
);

  localparam logic [DATA_W-1:0] REP_ONE = DATA_W'(1);

  state_e            state_q, state_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] dd_q, dd_d;
  // Pulses still to issue after the one currently on ctrl
  logic [DATA_W-1:0] rep_q, rep_d;
  logic              chk_q;
  logic              mismatch_q, mismatch_d;
  logic              diff;

  assign cmd_ready = (state_q == ST_IDLE);

  // Next-state and next-pulse; the pulse register is loaded at the accept edge
  // so the first pulse appears the cycle right after the handshake.
  always_comb begin
    state_d = state_q;
    ctrl_d  = CTRL_IDLE;
    dd_d    = '0;
    rep_d   = rep_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              ctrl_d  = CTRL_LOAD;
              dd_d    = cmd_data;
              rep_d   = '0;
              state_d = ST_ISSUE;
            end
            OP_LOAD_DBL: begin
              ctrl_d  = CTRL_LOAD_DBL;
              dd_d    = cmd_data;
              rep_d   = '0;
              state_d = ST_ISSUE;
            end
            OP_INC: begin
              // INC with zero repeats is consumed without a pulse
              if (cmd_data != '0) begin
                ctrl_d  = CTRL_INC;
                rep_d   = cmd_data - REP_ONE;
                state_d = ST_ISSUE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        if (rep_q != '0) begin
          ctrl_d = ctrl_q;
          rep_d  = rep_q - REP_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and pulse output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= CTRL_IDLE;
      dd_q    <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      dd_q    <= dd_d;
      rep_q   <= rep_d;
    end
  end

  shift_ref_model #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_model (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_i        (ctrl_q),
    .data_i        (dd_q),
    .exp_data_o    (exp_data),
    .exp_counter_o (exp_counter)
  );

  // The shifter and the model both update at the pulse-sampling edge, so the
  // compare belongs to the cycle after that edge.
  assign diff       = (dut_data_out != exp_data) || (dut_counter != exp_counter);
  assign mismatch_d = mismatch_q || (chk_q && diff);

  // Check-pending flag and sticky mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      chk_q      <= ctrl_q[CTRL_EN];
      mismatch_q <= mismatch_d;
    end
  end

  assign ctrl     = ctrl_q;
  assign dut_data = dd_q;
  assign busy     = (state_q == ST_ISSUE) || chk_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Randomized bench for shift_op_sequencer: a behavioural shifter drives the
// sequencer's compare inputs and a command-level model predicts every output.
module tb_shift_op_sequencer;
  import shift_seq_pkg::*;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [2:0]        ctrl;
  logic [DATA_W-1:0] dut_data;
  logic [DATA_W-1:0] dut_data_out;
  logic [CNT_W-1:0]  dut_counter;
  logic              busy;
  logic [DATA_W-1:0] exp_data;
  logic [CNT_W-1:0]  exp_counter;
  logic              mismatch;

  int n_chk_c = 0, n_err_c = 0;   // per-cycle compare process
  int n_chk_l = 0, n_err_l = 0;   // literal checks in the stimulus

  always #5 clk = ~clk;

  shift_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .ctrl(ctrl), .dut_data(dut_data),
    .dut_data_out(dut_data_out), .dut_counter(dut_counter), .busy(busy),
    .exp_data(exp_data), .exp_counter(exp_counter), .mismatch(mismatch)
  );

  // Behavioural shifter, with an injectable counter error
  logic [DATA_W-1:0] sh_data;
  logic [CNT_W-1:0]  sh_cnt;
  logic [CNT_W-1:0]  cnt_off;
  assign dut_data_out = sh_data;
  assign dut_counter  = sh_cnt + cnt_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data <= '0;
      sh_cnt  <= '0;
    end else if (ctrl[0]) begin
      if (ctrl[2]) begin
        sh_data <= sh_data + 4'd1;
        sh_cnt  <= sh_cnt + 8'd1;
      end else if (ctrl[1]) sh_data <= dut_data * 4'd2;
      else sh_data <= dut_data;
    end
  end

  // Command-level model: pulses left for the current command, model values,
  // pending check and sticky mismatch.
  int                m_rem;
  logic [1:0]        m_op;
  logic [DATA_W-1:0] m_opnd;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_chk;
  logic              m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_op <= OP_NOP; m_opnd <= '0;
      m_data <= '0; m_cnt <= '0; m_chk <= 1'b0; m_mis <= 1'b0;
    end else begin
      if (m_chk && (dut_data_out != m_data || dut_counter != m_cnt)) m_mis <= 1'b1;
      m_chk <= (m_rem != 0);
      if (m_rem != 0) begin
        case (m_op)
          OP_LOAD:     m_data <= m_opnd;
          OP_LOAD_DBL: m_data <= m_opnd * 4'd2;
          default: begin
            m_data <= m_data + 4'd1;
            m_cnt  <= m_cnt + 8'd1;
          end
        endcase
        m_rem <= m_rem - 1;
      end else if (cmd_valid) begin
        case (cmd_op)
          OP_LOAD, OP_LOAD_DBL: begin m_rem <= 1; m_op <= cmd_op; m_opnd <= cmd_data; end
          OP_INC:               begin m_rem <= int'(cmd_data); m_op <= cmd_op; end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle compare of every DUT output against the model
  always @(negedge clk) begin : cmp
    logic [2:0]        e_ctrl;
    logic [DATA_W-1:0] e_dd;
    if (rst_n) begin
      e_ctrl = 3'b000;
      e_dd   = '0;
      if (m_rem != 0) begin
        e_ctrl = (m_op == OP_LOAD) ? 3'b001 : (m_op == OP_LOAD_DBL) ? 3'b011 : 3'b101;
        e_dd   = (m_op == OP_INC) ? 4'd0 : m_opnd;
      end
      n_chk_c++;
      if (ctrl !== e_ctrl || dut_data !== e_dd || cmd_ready !== (m_rem == 0) ||
          busy !== (m_rem != 0 || m_chk) || exp_data !== m_data ||
          exp_counter !== m_cnt || mismatch !== m_mis) begin
        n_err_c++;
        $display("FAIL cycle t=%0t got ctrl=%b dd=%h rdy=%b busy=%b ed=%h ec=%0d mis=%b want ctrl=%b dd=%h rdy=%b busy=%b ed=%h ec=%0d mis=%b",
                 $time, ctrl, dut_data, cmd_ready, busy, exp_data, exp_counter, mismatch,
                 e_ctrl, e_dd, (m_rem == 0), (m_rem != 0 || m_chk), m_data, m_cnt, m_mis);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int want);
    n_chk_l++;
    if (act !== want) begin
      n_err_l++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] d);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) lit("send_timeout", t, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((!cmd_ready || busy) && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) lit("idle_timeout", t, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; cnt_off = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    lit("rst_ctrl", ctrl, 0);
    lit("rst_ready", cmd_ready, 1);
    lit("rst_busy", busy, 0);
    lit("rst_exp_data", exp_data, 0);
    lit("rst_mismatch", mismatch, 0);

    // LOAD 5
    send(OP_LOAD, 4'h5);
    lit("load_ctrl", ctrl, 3'b001);
    lit("load_dd", dut_data, 5);
    @(negedge clk);
    lit("load_ctrl_end", ctrl, 0);
    lit("load_exp_data", exp_data, 5);
    lit("load_exp_cnt", exp_counter, 0);

    // LOAD_DBL 9 -> 2
    send(OP_LOAD_DBL, 4'h9);
    lit("dbl_ctrl", ctrl, 3'b011);
    @(negedge clk);
    lit("dbl_exp_data", exp_data, 2);

    // LOAD E then INC 3 -> data wraps to 1, counter 3, ready low 3 cycles
    send(OP_LOAD, 4'hE);
    send(OP_INC, 4'd3);
    n = 0;
    while (!cmd_ready && n < 50) begin
      if (ctrl != 3'b101) lit("inc_ctrl", ctrl, 3'b101);
      n++; @(negedge clk);
    end
    lit("inc_ready_low", n, 3);
    lit("inc_exp_data", exp_data, 1);
    lit("inc_exp_cnt", exp_counter, 3);
    wait_idle();

    // 300 INC pulses from a clean counter
    do_reset();
    repeat (20) send(OP_INC, 4'd15);
    wait_idle();
    lit("wrap_exp_cnt", exp_counter, 44);
    lit("wrap_exp_data", exp_data, 12);
    lit("wrap_mismatch", mismatch, 0);

    // Forced counter error must raise a sticky mismatch two edges after the pulse
    cnt_off = 8'd1;
    send(OP_INC, 4'd1);
    @(negedge clk);
    lit("mis_not_yet", mismatch, 0);
    @(negedge clk);
    lit("mis_set", mismatch, 1);
    send(OP_NOP, 4'h7);
    lit("nop_ctrl", ctrl, 0);
    send(OP_INC, 4'd0);
    lit("inc0_ctrl", ctrl, 0);
    lit("inc0_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    lit("mis_sticky", mismatch, 1);
    lit("mis_cnt_kept", exp_counter, 45);
    cnt_off = 8'd0;

    // Reset at the fourth pulse of INC 10
    do_reset();
    send(OP_INC, 4'd10);
    repeat (3) @(negedge clk);
    lit("mid_ctrl", ctrl, 3'b101);
    lit("mid_cnt", exp_counter, 3);
    #2 rst_n = 1'b0;
    #1;
    lit("mid_rst_ctrl", ctrl, 0);
    lit("mid_rst_ready", cmd_ready, 1);
    lit("mid_rst_busy", busy, 0);
    lit("mid_rst_cnt", exp_counter, 0);
    lit("mid_rst_data", exp_data, 0);
    lit("mid_rst_mis", mismatch, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    send(OP_LOAD, 4'h7);
    lit("post_ctrl", ctrl, 3'b001);
    @(negedge clk);
    lit("post_data", exp_data, 7);

    // Random commands with random gaps, all checked by the per-cycle model
    repeat (80) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2'($urandom), 4'($urandom));
    end
    wait_idle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk_c + n_chk_l, n_err_c + n_err_l);
    $finish;
  end

endmodule
